// File: rtl/serial_frame_sender_if.sv
// Parallel-side handshake and serial line of the frame sender.
// The controller uses the master view; the sender uses the slave view.
interface serial_frame_sender_if #(
  parameter int ADDR_W = 2,
  parameter int LEN_W  = 4,
  parameter int DATA_W = 16
);
  logic              clkEn;
  logic              start;
  logic [ADDR_W-1:0] portSel;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] dataIn;
  logic              SerOut;
  logic              ready;
  logic              busy;
  logic              done;

  modport master (
    output clkEn, start, portSel, len, dataIn,
    input  SerOut, ready, busy, done
  );

  modport slave (
    input  clkEn, start, portSel, len, dataIn,
    output SerOut, ready, busy, done
  );
endinterface

// File: rtl/serial_frame_sender.sv
// Frame transmitter for the single-wire demux link:
// start bit, port address (MSB first), length (MSB first), payload (LSB first), stop bit.
module serial_frame_sender #(
  parameter int ADDR_W = 2,
  parameter int LEN_W  = 4,
  parameter int DATA_W = 16
) (
  input logic                  clk,
  input logic                  rst,
  serial_frame_sender_if.slave sif
);

  localparam int CNT_W = (LEN_W > ADDR_W) ? LEN_W : ADDR_W;

  typedef enum logic [2:0] {
    IDLE, ARMED, START, ADDR, LEN, DATA, STOP
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] port_sh;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  len_sh;
  logic [DATA_W-1:0] data_sh;
  logic [CNT_W-1:0]  cnt;
  logic              ser_q;
  logic              ready_q;
  logic              done_q;

  assign sif.SerOut = ser_q;
  assign sif.ready  = ready_q;
  assign sif.busy   = ~ready_q;
  assign sif.done   = done_q;

  // cnt holds the remaining bits of the address/length fields, and the
  // number of payload bits already sent while in DATA.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      port_sh <= '0;
      len_q   <= '0;
      len_sh  <= '0;
      data_sh <= '0;
      cnt     <= '0;
      ser_q   <= 1'b1;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (sif.start) begin
            port_sh <= sif.portSel;
            len_q   <= sif.len;
            len_sh  <= sif.len;
            data_sh <= sif.dataIn;
            ready_q <= 1'b0;
            state   <= ARMED;
          end
        end
        ARMED: begin
          if (sif.clkEn) begin
            ser_q <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (sif.clkEn) begin
            ser_q   <= port_sh[ADDR_W-1];
            port_sh <= port_sh << 1;
            cnt     <= CNT_W'(ADDR_W - 1);
            state   <= ADDR;
          end
        end
        ADDR: begin
          if (sif.clkEn) begin
            if (cnt == '0) begin
              ser_q  <= len_sh[LEN_W-1];
              len_sh <= len_sh << 1;
              cnt    <= CNT_W'(LEN_W - 1);
              state  <= LEN;
            end else begin
              ser_q   <= port_sh[ADDR_W-1];
              port_sh <= port_sh << 1;
              cnt     <= cnt - 1'b1;
            end
          end
        end
        LEN: begin
          if (sif.clkEn) begin
            if (cnt != '0) begin
              ser_q  <= len_sh[LEN_W-1];
              len_sh <= len_sh << 1;
              cnt    <= cnt - 1'b1;
            end else if (len_q != '0) begin
              ser_q   <= data_sh[0];
              data_sh <= data_sh >> 1;
              cnt     <= CNT_W'(1);
              state   <= DATA;
            end else begin
              ser_q <= 1'b1;
              state <= STOP;
            end
          end
        end
        DATA: begin
          if (sif.clkEn) begin
            if (cnt == CNT_W'(len_q)) begin
              ser_q <= 1'b1;
              state <= STOP;
            end else begin
              ser_q   <= data_sh[0];
              data_sh <= data_sh >> 1;
              cnt     <= cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (sif.clkEn) begin
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          ser_q   <= 1'b1;
          ready_q <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_sender.sv
// Directed bench for serial_frame_sender: hand-computed bit sequences,
// bit-rate stalls, ignored start, mid-frame reset and back-to-back frames.
module tb_serial_frame_sender;
  localparam int ADDR_W = 2;
  localparam int LEN_W  = 4;
  localparam int DATA_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;

  serial_frame_sender_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W)) sif ();

  serial_frame_sender #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .sif (sif)
  );

  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  int   en_div = 1;
  int   ph = 0;
  int   d0 = 0;
  logic en_used = 1'b0;
  logic clr_start = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) if (sif.done === 1'b1) done_cnt++;

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clk cycle; clkEn is high on one cycle in en_div.
  task automatic cyc();
    sif.clkEn = (en_div == 1) ? 1'b1 : (ph == 0);
    ph = (ph + 1) % en_div;
    en_used = sif.clkEn;
    @(posedge clk);
    #1;
    if (clr_start) begin
      sif.start = 1'b0;
      clr_start = 1'b0;
    end
  endtask

  task automatic send(input string tag, input logic [1:0] p, input logic [3:0] l,
                      input logic [15:0] d);
    sif.portSel = p;
    sif.len     = l;
    sif.dataIn  = d;
    sif.start   = 1'b1;
    cyc();
    sif.start = 1'b0;
    chk1({tag, " ready after capture"}, sif.ready, 1'b0);
    chk1({tag, " busy after capture"}, sif.busy, 1'b1);
    chk1({tag, " idle line after capture"}, sif.SerOut, 1'b1);
  endtask

  // Waits for the next clkEn edge, checking the line holds in between.
  task automatic wait_en(input string tag, input logic prev, output logic ok);
    int waited;
    waited  = 0;
    en_used = 1'b0;
    while (!en_used && waited < 8) begin
      cyc();
      waited++;
      if (!en_used) begin
        chk1({tag, " hold"}, sif.SerOut, prev);
        chk1({tag, " done quiet"}, sif.done, 1'b0);
      end
    end
    ok = en_used;
    if (!ok) begin
      total++;
      bad++;
      $error("FAIL %s: observed=no clkEn edge expected=clkEn edge", tag);
    end
  endtask

  // Frame just captured: check every bit (vec MSB = first bit), then done.
  task automatic run_frame(input string tag, input logic [63:0] vec, input int n,
                           input int inj);
    logic prev;
    logic ok;
    prev = 1'b1;
    for (int k = 0; k < n; k++) begin
      wait_en($sformatf("%s bit%0d", tag, k), prev, ok);
      if (!ok) return;
      chk1($sformatf("%s bit%0d", tag, k), sif.SerOut, vec[n-1-k]);
      chk1($sformatf("%s bit%0d done", tag, k), sif.done, 1'b0);
      prev = vec[n-1-k];
      if (k == inj) begin
        sif.start   = 1'b1;
        sif.portSel = 2'b00;
        sif.len     = 4'd15;
        sif.dataIn  = 16'hFFFF;
        clr_start   = 1'b1;
      end
    end
    wait_en({tag, " end"}, 1'b1, ok);
    if (!ok) return;
    chk1({tag, " done pulse"}, sif.done, 1'b1);
    chk1({tag, " ready at end"}, sif.ready, 1'b1);
    chk1({tag, " busy at end"}, sif.busy, 1'b0);
    chk1({tag, " line at end"}, sif.SerOut, 1'b1);
    cyc();
    chk1({tag, " done one cycle"}, sif.done, 1'b0);
  endtask

  initial begin
    sif.clkEn   = 1'b0;
    sif.start   = 1'b0;
    sif.portSel = '0;
    sif.len     = '0;
    sif.dataIn  = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk1("reset SerOut", sif.SerOut, 1'b1);
    chk1("reset ready", sif.ready, 1'b1);
    chk1("reset busy", sif.busy, 1'b0);
    chk1("reset done", sif.done, 1'b0);
    rst = 1'b1;
    cyc();
    cyc();

    // port 3, len 8, data A5 at full rate
    en_div = 1; ph = 0;
    d0 = done_cnt;
    send("s1", 2'b11, 4'd8, 16'h00A5);
    run_frame("s1", 64'h714B, 16, -1);
    chk1("s1 ready idle", sif.ready, 1'b1);
    chki("s1 done count", done_cnt - d0, 1);

    // empty payload
    d0 = done_cnt;
    send("s2", 2'b01, 4'd0, 16'hBEEF);
    run_frame("s2", 64'h21, 8, -1);
    chki("s2 done count", done_cnt - d0, 1);

    // same frame, one clkEn in three
    en_div = 3; ph = 1;
    d0 = done_cnt;
    send("s3", 2'b11, 4'd8, 16'h00A5);
    run_frame("s3", 64'h714B, 16, -1);
    chki("s3 done count", done_cnt - d0, 1);

    // start pulsed during the 5th bit is ignored
    en_div = 1; ph = 0;
    d0 = done_cnt;
    send("s4", 2'b11, 4'd8, 16'h00A5);
    run_frame("s4", 64'h714B, 16, 4);
    repeat (5) cyc();
    chk1("s4 line idle", sif.SerOut, 1'b1);
    chk1("s4 ready idle", sif.ready, 1'b1);
    chki("s4 done count", done_cnt - d0, 1);

    // reset in the payload of a len=15 frame
    d0 = done_cnt;
    send("s5", 2'b10, 4'd15, 16'h0000);
    repeat (10) cyc();
    chk1("s5 line low before reset", sif.SerOut, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk1("s5 async SerOut", sif.SerOut, 1'b1);
    chk1("s5 async ready", sif.ready, 1'b1);
    chk1("s5 async busy", sif.busy, 1'b0);
    chk1("s5 async done", sif.done, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk1("s5 held SerOut", sif.SerOut, 1'b1);
    rst = 1'b1;
    cyc();
    chki("s5 no done", done_cnt - d0, 0);
    send("s5b", 2'b01, 4'd0, 16'h0000);
    run_frame("s5b", 64'h21, 8, -1);

    // start held high: two back-to-back frames
    d0 = done_cnt;
    sif.portSel = 2'b00;
    sif.len     = 4'd15;
    sif.dataIn  = 16'h7FFF;
    sif.start   = 1'b1;
    cyc();
    chk1("s6 ready after capture", sif.ready, 1'b0);
    sif.portSel = 2'b10;
    sif.len     = 4'd3;
    sif.dataIn  = 16'h0005;
    run_frame("s6a", 64'h0FFFFF, 23, -1);
    sif.start = 1'b0;
    chk1("s6 second captured", sif.ready, 1'b0);
    run_frame("s6b", 64'h23B, 11, -1);
    chki("s6 done count", done_cnt - d0, 2);
    chk1("s6 ready idle", sif.ready, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
